micro_alpha_veryl_alu_sequencer: RTL and testbench
==================================================

MICRO_ALPHA_VERYL_ALU_SEQUENCER -- requirements
Module: micro_alpha_veryl_alu_sequencer

Interface
REQ-001 Parameter MAX_WORDS, default 4, SHALL set the maximum operand length in 16-bit MICRO1_MACHINE_WORDs (legal range 1..4).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-004 req_valid  input  1  SHALL indicate a request is offered.
REQ-005 req_ready  output  1  SHALL indicate the request is accepted this cycle.
REQ-006 req_operation  input  ALU_OPERATION  SHALL select ADD/SUB/AND/OR/XOR/NOP.
REQ-007 req_words  input  3  SHALL give the operand length in words.
REQ-008 req_left, req_right  input  64 each  SHALL carry the operands, word 0 in [15:0].
REQ-009 req_cin  input  1  SHALL carry the initial carry/borrow.
REQ-010 alu_operation, alu_left, alu_right, alu_cin  output  ALU_OPERATION/16/16/1  SHALL drive the shared ALU.
REQ-011 alu_result, alu_cout  input  16/1  SHALL return the combinational ALU outputs.
REQ-012 rsp_valid  output  1, rsp_ready  input  1  SHALL form the response handshake.
REQ-013 rsp_result  output  64, rsp_cout  output  1  SHALL carry the result and final carry/borrow.
REQ-014 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 req_ready SHALL equal (state == IDLE). A transfer SHALL occur on a rising edge with req_valid and req_ready both high.
REQ-017 On transfer, the block SHALL latch all req_* fields, set word index k=0, clear the result register, and go to RUN.
REQ-018 Effective length N SHALL be: 1 if req_words==0; MAX_WORDS if req_words>MAX_WORDS; otherwise req_words.
REQ-019 In RUN cycle k, alu_left/alu_right SHALL be word k of the latched operands and alu_operation SHALL be the latched operation.
REQ-020 For ADD/SUB, alu_cin SHALL be the latched cin when k=0 and the registered alu_cout of word k-1 when k>0.
REQ-021 For AND/OR/XOR/NOP, alu_cin SHALL be 0 for every word and rsp_cout SHALL be 0.
REQ-022 At the end of each RUN cycle, the block SHALL capture alu_result into result word k and alu_cout into the carry register, then increment k.
REQ-023 After word N-1 is captured, state SHALL go to DONE; rsp_valid SHALL first be high exactly N cycles after the accept edge.
REQ-024 For ADD/SUB, rsp_cout SHALL equal the alu_cout of word N-1.
REQ-025 Result words N..3 SHALL be 0.
REQ-026 In DONE, rsp_valid SHALL be 1 and rsp_result/rsp_cout SHALL be held stable until a rising edge with rsp_ready=1; at that edge the state SHALL return to IDLE.
REQ-027 No request SHALL be accepted in RUN or DONE; req_valid SHALL be ignored there.
REQ-028 In IDLE and DONE, alu_operation SHALL be NOP and alu_left, alu_right, alu_cin SHALL be 0.
REQ-029 An unknown operation encoding SHALL be treated as NOP.
REQ-030 The block SHALL add no combinational path from req_* to alu_* or to rsp_*.

Reset
REQ-031 While rst is low, state SHALL be IDLE and all registers SHALL be 0. Outputs SHALL read: rsp_valid=0, rsp_result=0, rsp_cout=0, busy=0, req_ready=1, alu_operation=NOP.
REQ-032 Reset asserted in RUN or DONE SHALL abort the operation immediately; no response SHALL be produced for it.

Verification
REQ-033 ADD, words=2, left=0x1FFF3, right=0xE, cin=0 -> rsp_result=0x0000_0000_0002_0001, rsp_cout=0, rsp_valid 2 cycles after accept.
REQ-034 SUB, words=4, left=2, right=5, cin=0 -> rsp_result=0xFFFF_FFFF_FFFF_FFFD, rsp_cout=1, latency 4.
REQ-035 XOR, words=3, left=all-ones, right=0x5A5A_5A5A_5A5A_5A5A, cin=1 -> rsp_result=0x0000_A5A5_A5A5_A5A5, rsp_cout=0, alu_cin=0 every cycle.
REQ-036 words=0, ADD 20+32, cin=1 -> treated as 1 word; rsp_result=53, rsp_cout=0, latency 1.
REQ-037 rsp_ready=0 for 5 cycles with req_valid=1 throughout -> rsp_* stable, req_ready=0, alu_operation=NOP, no second accept; accept occurs only after the response handshake.
REQ-038 rst low during RUN cycle 1 of a 4-word ADD -> rsp_valid=0 and busy=0 at once, req_ready=1, no response after release.

Source files
------------

// File: rtl/micro_alpha_veryl_alu_sequencer.sv
`timescale 1ns/1ps
// micro_alpha_veryl_alu_sequencer: runs a 1..MAX_WORDS x 16-bit operation word-serially through a shared external ALU.
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid_i/req_ready_o          request handshake (ready only in IDLE)
//   req_operation_i                  0=NOP 1=ADD 2=SUB 3=AND 4=OR 5=XOR, 6/7 act as NOP
//   req_words_i, req_left_i,
//   req_right_i, req_cin_i           length in words (0 means 1), operands (word 0 in [15:0]), initial carry/borrow
//   alu_*_o / alu_result_i,
//   alu_cout_i                       drive and return of the shared combinational ALU
//   rsp_valid_o/rsp_ready_i          response handshake, rsp_result_o/rsp_cout_o held while waiting
//   busy_o                           high whenever not IDLE
module micro_alpha_veryl_alu_sequencer #(
   parameter int MAX_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  req_operation_i,
   input  logic [2:0]  req_words_i,
   input  logic [63:0] req_left_i,
   input  logic [63:0] req_right_i,
   input  logic        req_cin_i,
   output logic [2:0]  alu_operation_o,
   output logic [15:0] alu_left_o,
   output logic [15:0] alu_right_o,
   output logic        alu_cin_o,
   input  logic [15:0] alu_result_i,
   input  logic        alu_cout_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_result_o,
   output logic        rsp_cout_o,
   output logic        busy_o
);
   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd5;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  k_q, k_d;
   logic [2:0]  n_q, n_d;
   logic [2:0]  op_q, op_d;
   logic [63:0] left_q, left_d, right_q, right_d, res_q, res_d;
   logic        carry_q, carry_d;
   logic        run, arith;
   assign run   = state_q == RUN;
   assign arith = op_q == OP_ADD || op_q == OP_SUB;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         n_q     <= '0;
         op_q    <= OP_NOP;
         left_q  <= '0;
         right_q <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         n_q     <= n_d;
         op_q    <= op_d;
         left_q  <= left_d;
         right_q <= right_d;
         res_q   <= res_d;
         carry_q <= carry_d;
      end
   end
   // carry_q starts as the request cin, so word 0 and later words share one carry path
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      n_d     = n_q;
      op_d    = op_q;
      left_d  = left_q;
      right_d = right_q;
      res_d   = res_q;
      carry_d = carry_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            state_d = RUN;
            k_d     = '0;
            n_d     = req_words_i == 3'd0 ? 3'd1 :
                      int'(req_words_i) > MAX_WORDS ? 3'(MAX_WORDS) : req_words_i;
            op_d    = req_operation_i > OP_XOR ? OP_NOP : req_operation_i;
            left_d  = req_left_i;
            right_d = req_right_i;
            carry_d = req_cin_i;
            res_d   = '0;
         end
         RUN: begin
            res_d[{k_q, 4'b0} +: 16] = alu_result_i;
            carry_d = alu_cout_i;
            k_d     = k_q + 2'd1;
            if ({1'b0, k_q} == n_q - 3'd1) state_d = DONE;
         end
         DONE: if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign req_ready_o     = state_q == IDLE;
   assign busy_o          = state_q != IDLE;
   assign rsp_valid_o     = state_q == DONE;
   assign rsp_result_o    = res_q;
   assign rsp_cout_o      = arith && carry_q;
   assign alu_operation_o = run ? op_q : OP_NOP;
   assign alu_left_o      = run ? left_q[{k_q, 4'b0} +: 16] : 16'd0;
   assign alu_right_o     = run ? right_q[{k_q, 4'b0} +: 16] : 16'd0;
   assign alu_cin_o       = run && arith && carry_q;
endmodule

// File: tb/tb_micro_alpha_veryl_alu_sequencer.sv
`timescale 1ns/1ps
// tb_micro_alpha_veryl_alu_sequencer: directed scoreboard bench with a behavioural 16-bit ALU attached.
module tb_micro_alpha_veryl_alu_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_cin = 1'b0;
   logic [2:0]  req_op = '0, req_words = '0;
   logic [63:0] req_left = '0, req_right = '0;
   logic [2:0]  alu_op;
   logic [15:0] alu_l, alu_r, alu_res;
   logic        alu_cin, alu_cout;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_cout, busy;
   logic [63:0] rsp_result;
   logic [16:0] t;
   int          vecs = 0, errs = 0;
   typedef struct {
      logic [63:0] res;
      logic        cout;
      int          lat;
   } exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   micro_alpha_veryl_alu_sequencer #(.MAX_WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_operation_i(req_op), .req_words_i(req_words),
      .req_left_i(req_left), .req_right_i(req_right), .req_cin_i(req_cin),
      .alu_operation_o(alu_op), .alu_left_o(alu_l), .alu_right_o(alu_r), .alu_cin_o(alu_cin),
      .alu_result_i(alu_res), .alu_cout_i(alu_cout),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_result_o(rsp_result), .rsp_cout_o(rsp_cout), .busy_o(busy)
   );
   always_comb begin
      t = '0;
      case (alu_op)
         3'd1: t = {1'b0, alu_l} + {1'b0, alu_r} + 17'(alu_cin);
         3'd2: t = {1'b0, alu_l} - {1'b0, alu_r} - 17'(alu_cin);
         3'd3: t = {1'b0, alu_l & alu_r};
         3'd4: t = {1'b0, alu_l | alu_r};
         3'd5: t = {1'b0, alu_l ^ alu_r};
         default: t = '0;
      endcase
   end
   assign alu_res  = t[15:0];
   assign alu_cout = t[16];
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic run(input logic [2:0] op, input logic [2:0] w, input logic [63:0] l, input logic [63:0] r,
                      input logic c, input int stall);
      exp_t e;
      int n, cyc;
      logic [63:0] m;
      logic [64:0] s;
      logic [2:0] eop;
      n = w == 0 ? 1 : w > 4 ? 4 : int'(w);
      m = 64'((65'd1 << (16 * n)) - 65'd1);
      eop = op > 3'd5 ? 3'd0 : op;
      s = '0;
      case (eop)
         3'd1: s = {1'b0, l & m} + {1'b0, r & m} + 65'(c);
         3'd2: s = {1'b0, l & m} - {1'b0, r & m} - 65'(c);
         3'd3: s = {1'b0, l & r};
         3'd4: s = {1'b0, l | r};
         3'd5: s = {1'b0, l ^ r};
         default: s = '0;
      endcase
      e.res  = s[63:0] & m;
      e.cout = (eop == 3'd1 || eop == 3'd2) ? s[16 * n] : 1'b0;
      e.lat  = n;
      q.push_back(e);
      @(negedge clk);
      req_op = op; req_words = w; req_left = l; req_right = r; req_cin = c; req_valid = 1'b1;
      check("req_ready_idle", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
         check("alu_op_run", 64'(alu_op), 64'(eop));
         if (eop != 3'd1 && eop != 3'd2) check("alu_cin_logic", 64'(alu_cin), 64'd0);
         if (cyc == 0 && (eop == 3'd1 || eop == 3'd2)) check("alu_cin_k0", 64'(alu_cin), 64'(c));
         @(posedge clk); #1;
         cyc++;
      end
      e = q.pop_front();
      check("latency", 64'(cyc), 64'(e.lat));
      check("rsp_result", rsp_result, e.res);
      check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         req_valid = 1'b1; req_op = 3'd1; req_words = 3'd1; req_left = 64'($urandom); req_right = 64'($urandom);
         check("stall_valid", 64'(rsp_valid), 64'd1);
         check("stall_result", rsp_result, e.res);
         check("stall_cout", 64'(rsp_cout), 64'(e.cout));
         check("stall_req_ready", 64'(req_ready), 64'd0);
         check("stall_alu_op", 64'(alu_op), 64'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check("post_hs_valid", 64'(rsp_valid), 64'd0);
      check("post_hs_busy", 64'(busy), 64'd0);
      check("post_hs_ready", 64'(req_ready), 64'd1);
   endtask
   initial begin
      #2;
      check("rst_valid", 64'(rsp_valid), 64'd0);
      check("rst_result", rsp_result, 64'd0);
      check("rst_cout", 64'(rsp_cout), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_alu_op", 64'(alu_op), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(3'd1, 3'd2, 64'h1FFF3, 64'hE, 1'b0, 0);
      check("add_spot", rsp_result, 64'h0000_0000_0002_0001);
      run(3'd2, 3'd4, 64'd2, 64'd5, 1'b0, 0);
      run(3'd5, 3'd3, '1, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 0);
      run(3'd1, 3'd0, 64'd20, 64'd32, 1'b1, 0);
      run(3'd3, 3'd2, 64'hFFFF_0F0F_1234_F0F0, 64'h0000_FFFF_FFFF_00FF, 1'b0, 5);
      run(3'd4, 3'd7, 64'h8000_0000_0000_0001, 64'h0001_0000_0000_8000, 1'b0, 0);
      run(3'd7, 3'd2, 64'hAAAA_BBBB, 64'h1111_2222, 1'b1, 0);
      run(3'd2, 3'd1, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0003, 1'b1, 0);
      for (int i = 0; i < 4; i++)
         run(3'($urandom_range(1, 5)), 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), 0);
      @(negedge clk);
      req_op = 3'd1; req_words = 3'd4; req_left = '1; req_right = 64'd1; req_cin = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", 64'(rsp_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ready", 64'(req_ready), 64'd1);
      check("abort_alu_op", 64'(alu_op), 64'd0);
      check("abort_result", rsp_result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("abort_no_rsp", 64'(rsp_valid), 64'd0);
      end
      run(3'd1, 3'd4, '1, 64'd1, 1'b0, 0);
      check("queue_empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
